// File: rtl/mau_pkg.sv
// Shared encodings, FSM state type and fault check for the memory access unit.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} mau_state_e;

  // Misaligned, illegal size or beyond the end of memory.
  // Addresses are widened to 64 bits so the limit compare never overflows.
  function automatic logic mau_fault(input logic [1:0]  size,
                                     input logic [63:0] addr,
                                     input logic [63:0] limit);
    logic f;
    f = (addr >= limit);
    case (size)
      SZ_BYTE: f = f;
      SZ_HALF: f = f | addr[0];
      SZ_WORD: f = f | (addr[1:0] != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane extract for loads and lane merge for sub-word stores.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane, extend it, and splice store data into the read word.
  always_comb begin
    w_byte  = i_rdata[{i_lane, 3'b000} +: 8];
    w_half  = i_rdata[{i_lane[1], 4'b0000} +: 16];
    o_load  = i_rdata;
    o_merge = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_load = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
        o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
        o_merge[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: begin
        o_load  = i_rdata;
        o_merge = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one access per handshake, sub-word stores as read-modify-write,
// registered single-cycle memory strobes and a one-cycle response pulse.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_fault,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [63:0] ADDR_LIMIT = 64'(MEM_WORDS) * 64'd4;

  mau_state_e        r_state, w_state_d;
  logic              r_we, r_unsigned;
  logic [1:0]        r_size, r_lane;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_d;
  logic [31:0]       r_mem_wdata, w_mem_wdata_d;
  logic              r_mem_read, w_mem_read_d;
  logic              r_mem_write, w_mem_write_d;
  logic              r_resp_valid, w_resp_valid_d;
  logic [31:0]       r_resp_rdata, w_resp_rdata_d;
  logic              r_resp_fault, w_resp_fault_d;
  logic              w_accept, w_req_fault;
  logic [31:0]       w_load, w_merge;

  assign w_accept    = i_req_valid && (r_state == IDLE);
  assign w_req_fault = mau_fault(i_req_size, 64'(i_req_addr), ADDR_LIMIT);

  mau_lane_align u_lane_align (
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_rdata    (i_mem_rdata),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_d;
  end

  // Next-state: faults skip memory, sub-word stores read first.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_fault)                             w_state_d = RESP;
          else if (!i_req_we || i_req_size != SZ_WORD) w_state_d = RD;
          else                                         w_state_d = WR;
        end
      end
      RD:      w_state_d = r_we ? WR : RESP;
      WR:      w_state_d = RESP;
      RESP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, aligned with the state they belong to.
  always_comb begin
    w_mem_read_d   = (w_state_d == RD);
    w_mem_write_d  = (w_state_d == WR);
    w_resp_valid_d = (w_state_d == RESP);
    w_resp_fault_d = w_accept && w_req_fault;
    w_resp_rdata_d = '0;
    if (r_state == RD && !r_we) w_resp_rdata_d = w_load;
    w_mem_addr_d = '0;
    if (w_state_d == RD || w_state_d == WR) begin
      w_mem_addr_d = (r_state == IDLE) ? {2'b00, i_req_addr[ADDR_W-1:2]} : r_mem_addr;
    end
    w_mem_wdata_d = '0;
    if (w_state_d == WR) w_mem_wdata_d = (r_state == IDLE) ? i_req_wdata : w_merge;
  end

  // Request latches and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= '0;
      r_lane       <= '0;
      r_wdata      <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we       <= i_req_we;
        r_unsigned <= i_req_unsigned;
        r_size     <= i_req_size;
        r_lane     <= i_req_addr[1:0];
        r_wdata    <= i_req_wdata;
      end
      r_mem_addr   <= w_mem_addr_d;
      r_mem_wdata  <= w_mem_wdata_d;
      r_mem_read   <= w_mem_read_d;
      r_mem_write  <= w_mem_write_d;
      r_resp_valid <= w_resp_valid_d;
      r_resp_rdata <= w_resp_rdata_d;
      r_resp_fault <= w_resp_fault_d;
    end
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_fault = r_resp_fault;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_read   = r_mem_read;
  assign o_mem_write  = r_mem_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 256-word level-sensitive memory model.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  int checks = 0;
  int failures = 0;
  int both_hi = 0;
  logic [31:0] g_wr_addr;
  logic [31:0] t5_exp [3] = '{32'h000000A1, 32'h000000A2, 32'h000000A3};

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(256), .ADDR_W(32)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_resp_valid   (resp_valid),
    .o_resp_rdata   (resp_rdata),
    .o_resp_fault   (resp_fault),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .i_mem_rdata    (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_write)   mem[mem_addr[7:0]] <= mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  always @(negedge clk) if (mem_read && mem_write) both_hi++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // One request from an idle unit; checks latency, response and strobe counts.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_f, input int exp_lat,
                        input int exp_rdc, input int exp_wrc);
    int lat, rdc, wrc;
    @(negedge clk);
    chk({tag, "_idle"}, {29'b0, req_ready, resp_valid, resp_fault}, 32'h4);
    chk({tag, "_idle_rdata"}, resp_rdata, 32'h0);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rdc = 0; wrc = 0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge clk);
      if (mem_read) rdc++;
      if (mem_write) begin wrc++; g_wr_addr = mem_addr; end
      if (resp_valid) begin
        lat = i;
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
        chk({tag, "_fault"}, {31'b0, resp_fault}, {31'b0, exp_f});
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_reads"}, rdc, exp_rdc);
    chk({tag, "_writes"}, wrc, exp_wrc);
  endtask

  initial begin
    int idx, nresp, last_acc, nvalid, saw_wr;
    logic acc;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; g_wr_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_flags", {28'b0, resp_valid, resp_fault, mem_read, mem_write}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    reset = 1'b0;

    // 1: word store then word load
    do_req("t1_sw", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1);
    chk("t1_wr_addr", g_wr_addr, 32'h4);
    chk("t1_mem", mem[4], 32'hDEADBEEF);
    do_req("t1_lw", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);

    // 2: lane extract and extension
    preload(8'd8, 32'h11223344);
    do_req("t2_lb23", 1'b0, SZ_BYTE, 1'b0, 32'h23, 32'h0, 32'h00000011, 1'b0, 2, 1, 0);
    do_req("t2_lb21", 1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 32'h00000033, 1'b0, 2, 1, 0);
    do_req("t2_lbu20", 1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, 32'h00000044, 1'b0, 2, 1, 0);
    preload(8'd8, 32'h80FF0000);
    do_req("t2_lh22", 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1, 0);
    do_req("t2_lhu22", 1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'h000080FF, 1'b0, 2, 1, 0);
    do_req("t2_lb23n", 1'b0, SZ_BYTE, 1'b0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0);
    do_req("t2_lwu", 1'b0, SZ_WORD, 1'b1, 32'h20, 32'h0, 32'h80FF0000, 1'b0, 2, 1, 0);

    // 3: read-modify-write stores
    preload(8'd8, 32'h11223344);
    do_req("t3_sb21", 1'b1, SZ_BYTE, 1'b0, 32'h21, 32'hFFFFFFAB, 32'h0, 1'b0, 3, 1, 1);
    chk("t3_mem_sb", mem[8], 32'h1122AB44);
    do_req("t3_sh22", 1'b1, SZ_HALF, 1'b0, 32'h22, 32'h1234BEEF, 32'h0, 1'b0, 3, 1, 1);
    chk("t3_mem_sh", mem[8], 32'hBEEFAB44);

    // 4: faults, plus the last legal byte
    do_req("t4_lh13", 1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("t4_sw06", 1'b1, SZ_WORD, 1'b0, 32'h06, 32'h12345678, 32'h0, 1'b1, 1, 0, 0);
    do_req("t4_sz11", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("t4_lw400", 1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    preload(8'd255, 32'hA5000000);
    do_req("t4_lb3ff", 1'b0, SZ_BYTE, 1'b0, 32'h3FF, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 1, 0);
    chk("t4_mem6", mem[1], 32'hx);

    // 5: req_valid held high across three loads
    preload(8'd1, 32'hA1);
    preload(8'd2, 32'hA2);
    preload(8'd3, 32'hA3);
    @(negedge clk);
    req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h4;
    req_valid = 1'b1;
    idx = 0; nresp = 0; last_acc = -1; nvalid = 0;
    for (int cyc = 0; cyc < 40 && nresp < 3; cyc++) begin
      if (resp_valid) begin
        chk("t5_rdata", resp_rdata, t5_exp[nresp]);
        nresp++;
      end
      acc = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (last_acc >= 0) chk("t5_spacing", cyc - last_acc, 3);
        last_acc = cyc;
        idx++;
        if (idx < 3) req_addr = 32'h4 * (idx + 1);
        else         req_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("t5_accepts", idx, 3);
    chk("t5_resps", nresp, 3);

    // 6: reset during the write cycle of a byte store
    preload(8'd8, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_addr = 32'h21;
    req_wdata = 32'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    saw_wr = 0;
    for (int i = 0; i < 5 && saw_wr == 0; i++) begin
      @(negedge clk);
      if (mem_write) saw_wr = 1;
    end
    chk("t6_saw_write", saw_wr, 1);
    reset = 1'b1;
    #1;
    chk("t6_write_drop", {31'b0, mem_write}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) nvalid++;
    end
    chk("t6_no_resp", nvalid, 0);
    chk("t6_ready", {31'b0, req_ready}, 32'h1);
    chk("t6_mem", mem[8], 32'h11223344);
    chk("rw_exclusive", both_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
